result_store_ctrl: RTL and testbench

- Downstream of the matrix-multiply ALU.
- Captures the four 18-bit row results (MU1..MU4) on each write strobe and buffers them in a 2-entry queue.
- Serializes the queue into one-word-per-cycle writes to the output single-port SRAM, with auto-incrementing addresses per frame.
- Reports frame completion, and flags overflow and frame-length errors to the controller.

---
 rtl/result_store_ctrl_pkg.sv | 10 +
 rtl/result_store_ctrl_fifo.sv | 47 ++++
 rtl/result_store_ctrl.sv | 146 ++++++++++++++
 tb/tb_result_store_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_store_ctrl_pkg.sv
// result_store_pkg: shared widths, frame length, FSM states and result-group type
// for the result store controller.
package result_store_pkg;
    localparam int RES_W = 18;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int RES_PER_FRAME = 16;
    typedef enum logic {IDLE, WRITE} state_t;
    typedef logic [3:0][RES_W-1:0] group_t;
endpackage

// File: rtl/result_store_ctrl_fifo.sv
// result_fifo: 2-entry queue of result groups; a push is accepted together with
// a pop even when full.
module result_fifo
    import result_store_pkg::*;
#(
    parameter int W = $bits(group_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem_q [2];
    logic         wr_q, wr_d, rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        wr_d  = clear ? 1'b0 : wr_q ^ push;
        rd_d  = clear ? 1'b0 : rd_q ^ pop;
        cnt_d = clear ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign full  = cnt_q == 2'd2;
    assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/result_store_ctrl.sv
// result_store_ctrl: buffers MU1..MU4 result groups and writes them one word per
// cycle to the output SRAM. `define RESULT_MAX_EN adds per-frame maximum tracking.
module result_store_ctrl #(
    parameter int RES_W = 18,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int RES_PER_FRAME = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [RES_W-1:0]  MU1,
    input  logic [RES_W-1:0]  MU2,
    input  logic [RES_W-1:0]  MU3,
    input  logic [RES_W-1:0]  MU4,
    input  logic              web,
    input  logic              ALU_done,
    output logic              ram_csn,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              store_done,
    output logic              ovf_err,
    output logic              frame_err,
    output logic [RES_W-1:0]  max_val,
    output logic [ADDR_W-1:0] max_addr
);
    import result_store_pkg::*;

    state_t                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [ADDR_W-1:0]       word_cnt_q, word_cnt_d, base_q, base_d, grp_cnt_q, grp_cnt_d;
    logic                    ovf_q, ovf_d, frame_err_q, frame_err_d, done_q, done_d;
    logic                    active, pop, push, last, full, empty;
    logic [3:0][RES_W-1:0]   head;
    logic [RES_W-1:0]        lane_res;
    logic [ADDR_W+1:0]       words;

    result_fifo #(.W(4 * RES_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   ({MU4, MU3, MU2, MU1}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // WRITE is held exactly while the queue holds an entry, so a strobe is
    // written on the very next cycle with no IDLE bubble.
    always_comb begin
        active      = state_q == WRITE;
        lane_res    = head[lane_q];
        pop         = active && lane_q == 2'd3;
        push        = web && (!full || pop);
        last        = active && word_cnt_q == ADDR_W'(RES_PER_FRAME - 1);
        words       = {grp_cnt_q + ADDR_W'(push), 2'b00};
        state_d     = (push || full || (!empty && !pop)) ? WRITE : IDLE;
        lane_d      = active ? lane_q + 2'd1 : 2'd0;
        word_cnt_d  = last ? '0 : word_cnt_q + ADDR_W'(active);
        base_d      = last ? base_q + ADDR_W'(RES_PER_FRAME) : base_q;
        grp_cnt_d   = ALU_done ? '0 : grp_cnt_q + ADDR_W'(push);
        frame_err_d = frame_err_q || (ALU_done && words != (ADDR_W + 2)'(RES_PER_FRAME));
        ovf_d       = ovf_q || (web && !push);
        done_d      = last;
        if (clear) begin
            state_d     = IDLE;
            lane_d      = 2'd0;
            word_cnt_d  = '0;
            base_d      = '0;
            grp_cnt_d   = '0;
            frame_err_d = 1'b0;
            ovf_d       = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lane_q      <= 2'd0;
            word_cnt_q  <= '0;
            base_q      <= '0;
            grp_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            word_cnt_q  <= word_cnt_d;
            base_q      <= base_d;
            grp_cnt_q   <= grp_cnt_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    assign ram_csn    = !active;
    assign ram_wen    = !active;
    assign ram_addr   = base_q + word_cnt_q;
    assign ram_wdata  = active ? DATA_W'(lane_res) : '0;
    assign store_done = done_q;
    assign ovf_err    = ovf_q;
    assign frame_err  = frame_err_q;

`ifdef RESULT_MAX_EN
    logic [RES_W-1:0]  max_val_q, max_val_d;
    logic [ADDR_W-1:0] max_addr_q, max_addr_d;
    logic              first_q, first_d, upd;

    // The first write of a frame always seeds the tracker; ties keep the older address.
    always_comb begin
        upd        = active && (first_q || lane_res > max_val_q);
        max_val_d  = upd ? lane_res : max_val_q;
        max_addr_d = upd ? ram_addr : max_addr_q;
        first_d    = last || (first_q && !active);
        if (clear) begin
            max_val_d  = '0;
            max_addr_d = '0;
            first_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_val_q  <= '0;
            max_addr_q <= '0;
            first_q    <= 1'b1;
        end else begin
            max_val_q  <= max_val_d;
            max_addr_q <= max_addr_d;
            first_q    <= first_d;
        end
    end

    assign max_val  = upd ? lane_res : max_val_q;
    assign max_addr = upd ? ram_addr : max_addr_q;
`else
    assign max_val  = '0;
    assign max_addr = '0;
`endif
endmodule

// File: tb/tb_result_store_ctrl.sv
// tb_result_store_ctrl: directed stimulus with a write scoreboard holding the
// expected address, data and cycle of every SRAM write.
module tb_result_store_ctrl;
    localparam int RES_W = 18;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    logic              clk = 0, rst = 0, clear = 0, web = 0, ALU_done = 0;
    logic [RES_W-1:0]  MU1 = 0, MU2 = 0, MU3 = 0, MU4 = 0;
    logic              ram_csn, ram_wen, store_done, ovf_err, frame_err;
    logic [ADDR_W-1:0] ram_addr, max_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [RES_W-1:0]  max_val;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    wr_t               exp_q[$];
    int                n_chk = 0, n_fail = 0, cyc = 0, last_cyc = 0;
    logic [ADDR_W-1:0] exp_addr = 0;
    logic              sd_exp = 0;

    result_store_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .MU1        (MU1),
        .MU2        (MU2),
        .MU3        (MU3),
        .MU4        (MU4),
        .web        (web),
        .ALU_done   (ALU_done),
        .ram_csn    (ram_csn),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .store_done (store_done),
        .ovf_err    (ovf_err),
        .frame_err  (frame_err),
        .max_val    (max_val),
        .max_addr   (max_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_csn", ram_csn, 1);
        check("rst_wen", ram_wen, 1);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_store_done", store_done, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_max_val", max_val, 0);
        check("rst_max_addr", max_addr, 0);
    endtask

    task automatic sample();
        wr_t e;
        if (!rst) return;
        check("store_done", store_done, sd_exp);
        sd_exp = 0;
        if (!ram_csn) begin
            check("ram_wen", ram_wen, 0);
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ram_addr", ram_addr, e.addr);
                check("ram_wdata", ram_wdata, e.data);
                check("write_cycle", cyc, e.cyc);
                sd_exp = e.addr[3:0] == 4'hF;
            end
        end else begin
            check("ram_wen_idle", ram_wen, 1);
        end
    endtask

    task automatic step(input logic w, input logic [RES_W-1:0] a, b, c, d,
                        input logic acc, input logic done, input logic clr);
        logic [RES_W-1:0] v [4];
        int s;
        @(posedge clk);
        #1;
        web = w; MU1 = a; MU2 = b; MU3 = c; MU4 = d; ALU_done = done; clear = clr;
        v = '{a, b, c, d};
        if (clr) exp_addr = 0;
        if (w && acc) begin
            s = (cyc + 1 > last_cyc + 1) ? cyc + 1 : last_cyc + 1;
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back('{addr: exp_addr, data: DATA_W'(v[k]), cyc: s + k});
                exp_addr++;
            end
            last_cyc = s + 3;
        end
        @(negedge clk);
        sample();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic grp(input logic [RES_W-1:0] a, b, c, d, input logic acc);
        step(1, a, b, c, d, acc, 0, 0);
    endtask

    task automatic do_clear();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        rst = 1;
        idle(2);
        check("csn_before", ram_csn, 1);
        grp(1, 2, 3, 4, 1);
        idle(6);
        check("drained_single", exp_q.size(), 0);
        check("csn_after", ram_csn, 1);

        // full frame: four strobes 8 cycles apart, then ALU_done
        do_clear();
        idle(1);
        for (int g = 0; g < 4; g++) begin
            grp(RES_W'(18'h100 * g + 1), RES_W'(18'h100 * g + 2), RES_W'(18'h100 * g + 3),
                (g == 3) ? 18'h3FFFF : RES_W'(18'h100 * g + 4), 1);
            idle(7);
        end
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        check("frame_err_ok", frame_err, 0);
        check("drained_frame", exp_q.size(), 0);
`ifndef RESULT_MAX_EN
        check("max_val_tied", max_val, 0);
        check("max_addr_tied", max_addr, 0);
`endif

        // back-to-back strobes from the second frame base; third dropped
        grp(18'h11, 18'h12, 18'h13, 18'h14, 1);
        grp(18'h21, 18'h22, 18'h23, 18'h24, 1);
        grp(18'h31, 18'h32, 18'h33, 18'h34, 0);
        idle(1);
        check("ovf_set", ovf_err, 1);
        idle(8);
        check("ovf_sticky", ovf_err, 1);
        check("drained_b2b", exp_q.size(), 0);

        // push on the cycle the full queue pops its head: accepted
        do_clear();
        idle(1);
        check("ovf_cleared", ovf_err, 0);
        grp(18'h41, 18'h42, 18'h43, 18'h44, 1);
        grp(18'h51, 18'h52, 18'h53, 18'h54, 1);
        idle(2);
        grp(18'h61, 18'h62, 18'h63, 18'h64, 1);
        idle(14);
        check("ovf_edge", ovf_err, 0);
        check("drained_edge", exp_q.size(), 0);

        // clear beats web; short frame raises frame_err
        step(1, 18'h7, 18'h7, 18'h7, 18'h7, 0, 0, 1);
        idle(2);
        check("addr_after_clear", ram_addr, 0);
        grp(18'h71, 18'h72, 18'h73, 18'h74, 1);
        idle(3);
        grp(18'h81, 18'h82, 18'h83, 18'h84, 1);
        idle(5);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        check("frame_err_set", frame_err, 1);
        idle(5);
        check("frame_err_sticky", frame_err, 1);
        check("addr_short_frame", ram_addr, 8);
        check("drained_short", exp_q.size(), 0);
        do_clear();
        idle(1);
        check("frame_err_cleared", frame_err, 0);
        check("addr_cleared", ram_addr, 0);

        // asynchronous reset during the lane-2 write
        grp(18'h91, 18'h92, 18'h93, 18'h94, 1);
        idle(2);
        @(posedge clk);
        @(negedge clk);
        sample();
        #1 rst = 0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        exp_addr = 0;
        last_cyc = 0;
        repeat (2) @(negedge clk);
        #1 rst = 1;
        idle(6);
        check("csn_after_reset", ram_csn, 1);
        grp(18'hA1, 18'hA2, 18'hA3, 18'hA4, 1);
        idle(6);
        check("drained_reset", exp_q.size(), 0);

`ifdef RESULT_MAX_EN
        do_clear();
        idle(1);
        grp(18'd5, 18'd1, 18'd2, 18'd3, 1);
        idle(4);
        grp(18'd4, 18'd0, 18'h3FFFF, 18'd7, 1);
        idle(4);
        grp(18'd8, 18'h3FFFF, 18'd16, 18'd17, 1);
        idle(4);
        grp(18'd1, 18'd1, 18'd1, 18'd1, 1);
        idle(8);
        check("max_val", max_val, 18'h3FFFF);
        check("max_addr", max_addr, 6);
        check("drained_max", exp_q.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
